alu_result_stage: RTL and testbench

- Downstream consumer of the 16-bit ALU (combinational, 3-bit opcode, result plus final carry).
- Captures each ALU result together with its opcode and operands, and derives Z/N/C/V status flags.
- Buffers results in a small FIFO and hands them to writeback over a valid/ready handshake.
- Keeps a sticky signed-overflow flag and a 16-bit count of completed results.

---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/alu_flag_fifo.sv | 78 +++++++
 rtl/alu_result_stage.sv | 91 +++++++++
 tb/tb_alu_result_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and flag derivation for the ALU result stage.
// Opcode map, the {z,n,c,v} status record and the per-opcode flag rules.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_INC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_ZERO = 3'b100,
        OP_OR   = 3'b101,
        OP_AND  = 3'b110,
        OP_XOR  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Carry is only meaningful for arithmetic ops; for SUB/DEC a set carry means "no borrow".
    function automatic flags_t calc_flags(
        input alu_op_e                op,
        input logic [ALU_WIDTH-1:0]   a,
        input logic [ALU_WIDTH-1:0]   b,
        input logic [ALU_WIDTH-1:0]   y,
        input logic                   carry
    );
        flags_t f;
        f.z = (y == {ALU_WIDTH{1'b0}});
        f.n = y[ALU_WIDTH-1];
        f.c = 1'b0;
        f.v = 1'b0;
        case (op)
            OP_ADD: begin
                f.c = carry;
                f.v = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) && (y[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
            end
            OP_INC: begin
                f.c = carry;
                f.v = (a == {1'b0, {(ALU_WIDTH-1){1'b1}}});
            end
            OP_SUB: begin
                f.c = carry;
                f.v = (a[ALU_WIDTH-1] != b[ALU_WIDTH-1]) && (y[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
            end
            OP_DEC: begin
                f.c = carry;
                f.v = (a == {1'b1, {(ALU_WIDTH-1){1'b0}}});
            end
            default: begin
                f.c = 1'b0;
                f.v = 1'b0;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_fifo.sv
// DEPTH x DW synchronous FIFO with occupancy output, async reset and sync clear.
// Full/empty come from the level register so they never depend on same-cycle handshakes.
module alu_flag_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // Qualify requests against occupancy; clear wins over both.
    always_comb begin
        wr_en_s = push & ~full & ~clear;
        rd_en_s = pop & ~empty & ~clear;
    end

    assign full  = (level_r == LVL_FULL);
    assign empty = (level_r == {(AW+1){1'b0}});
    assign level = level_r;
    assign rdata = mem_r[rd_ptr_r];

    // Entry storage; zeroed on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result capture stage: derives Z/N/C/V, buffers {flags,result} for writeback,
// and tracks a sticky signed-overflow flag plus a count of delivered results.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_sticky,
    output logic [15:0]              res_count,
    input  logic                     clear
);

    flags_t               flags_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [WIDTH+3:0]     wdata_s;
    logic [WIDTH+3:0]     rdata_s;
    logic                 ovf_sticky_r;
    logic [15:0]          res_count_r;

    // Flag derivation and handshake qualification for the incoming result.
    always_comb begin
        flags_s = calc_flags(alu_op_e'(in_op), in_a, in_b, in_y, in_carry);
        push_s  = in_valid & ~full_s;
        pop_s   = out_ready & ~empty_s;
        wdata_s = {flags_s, in_y};
    end

    alu_flag_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign in_ready   = ~full_s;
    assign out_valid  = ~empty_s;
    assign out_y      = rdata_s[WIDTH-1:0];
    assign out_flags  = rdata_s[WIDTH+3:WIDTH];
    assign ovf_sticky = ovf_sticky_r;
    assign res_count  = res_count_r;

    // Sticky overflow: any accepted entry with V set; a push discarded by clear does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (clear) begin
            ovf_sticky_r <= 1'b0;
        end else if (push_s && flags_s.v) begin
            ovf_sticky_r <= 1'b1;
        end
    end

    // Delivered-result counter, free-running wrap at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count_r <= 16'd0;
        end else if (clear) begin
            res_count_r <= 16'd0;
        end else if (pop_s) begin
            res_count_r <= res_count_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vectors from a table, then
// full/backpressure, steady-state wrap, clear and mid-stream reset sequences.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_y;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic [3:0]  out_flags;
    logic [2:0]  level;
    logic        ovf_sticky;
    logic [15:0] res_count;
    logic        clear;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        c;
        logic [3:0]  ef;
        logic        es;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_y       (in_y),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .level      (level),
        .ovf_sticky (ovf_sticky),
        .res_count  (res_count),
        .clear      (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        // op, a, b, y, carry, expected {Z,N,C,V}, expected sticky
        vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4'b0101, 1'b1};
        vecs[1]  = '{3'b010, 16'h0005, 16'h0005, 16'h0000, 1'b1, 4'b1010, 1'b1};
        vecs[2]  = '{3'b011, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 4'b0011, 1'b1};
        vecs[3]  = '{3'b111, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b1, 4'b0100, 1'b1};
        vecs[4]  = '{3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 4'b0000, 1'b1};
        vecs[5]  = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 4'b1011, 1'b1};
        vecs[6]  = '{3'b001, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 4'b0101, 1'b1};
        vecs[7]  = '{3'b001, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 4'b1010, 1'b1};
        vecs[8]  = '{3'b010, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 4'b0011, 1'b1};
        vecs[9]  = '{3'b010, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 4'b0100, 1'b1};
        vecs[10] = '{3'b110, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 4'b1000, 1'b1};
        vecs[11] = '{3'b101, 16'h8000, 16'h0001, 16'h8001, 1'b1, 4'b0100, 1'b1};
        vecs[12] = '{3'b100, 16'h1234, 16'h5678, 16'h0000, 1'b1, 4'b1000, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 16'h0; in_b = 16'h0;
        in_y = 16'h0; in_carry = 1'b0; out_ready = 1'b0; clear = 1'b0;
        repeat (2) tick();

        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_level", level, 32'd0);
        chk("rst_sticky", ovf_sticky, 32'd0);
        chk("rst_count", res_count, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_flags", out_flags, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: each push pops the previous head on the same edge.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a;
            in_b = vecs[i].b; in_y = vecs[i].y; in_carry = vecs[i].c;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 32'd1);
            chk($sformatf("vec%0d_y", i), out_y, {16'h0, vecs[i].y});
            chk($sformatf("vec%0d_flags", i), out_flags, {28'h0, vecs[i].ef});
            chk($sformatf("vec%0d_sticky", i), ovf_sticky, {31'h0, vecs[i].es});
        end
        tick();
        chk("tbl_count", res_count, 32'd13);
        chk("tbl_level", level, 32'd0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr1_count", res_count, 32'd0);
        chk("clr1_sticky", ovf_sticky, 32'd0);

        // Fill under backpressure; the fifth push must be dropped.
        out_ready = 1'b0; in_op = 3'b101; in_a = 16'h0; in_b = 16'h0; in_carry = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_y = 16'h0100 + 16'(i);
            chk($sformatf("fill%0d_in_ready", i), in_ready, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_level", level, 32'd4);
        chk("full_in_ready", in_ready, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), out_valid, 32'd1);
            chk($sformatf("drain%0d_y", k), out_y, 32'h0100 + k);
            tick();
        end
        chk("drain_empty", out_valid, 32'd0);
        chk("drain_count", res_count, 32'd4);
        tick();
        chk("empty_pop_count", res_count, 32'd4);

        // Steady push+pop at level 2, crossing the pointer wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_y = 16'h0200 + 16'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_y = 16'h0202 + 16'(k);
            chk($sformatf("steady%0d_y", k), out_y, 32'h0200 + k);
            tick();
            chk($sformatf("steady%0d_level", k), level, 32'd2);
        end
        in_valid = 1'b0;
        chk("steady_tail0", out_y, 32'h0208);
        tick();
        chk("steady_tail1", out_y, 32'h0209);
        tick();
        chk("steady_count", res_count, 32'd14);

        // Clear with a concurrent overflowing push.
        out_ready = 1'b0; in_op = 3'b000; in_a = 16'h7FFF; in_b = 16'h0001; in_y = 16'h8000;
        in_valid = 1'b1;
        repeat (3) tick();
        chk("pre_clr_level", level, 32'd3);
        chk("pre_clr_sticky", ovf_sticky, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_level", level, 32'd0);
        chk("clr_valid", out_valid, 32'd0);
        chk("clr_count", res_count, 32'd0);
        chk("clr_sticky", ovf_sticky, 32'd0);
        chk("clr_in_ready", in_ready, 32'd1);

        // Asynchronous reset mid-stream.
        in_op = 3'b101; in_a = 16'h0; in_b = 16'h0; in_y = 16'h3333; in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_count", res_count, 32'd1);
        chk("pre_rst_y", out_y, 32'h3333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 32'd0);
        chk("arst_level", level, 32'd0);
        chk("arst_in_ready", in_ready, 32'd1);
        chk("arst_count", res_count, 32'd0);
        chk("arst_out_y", out_y, 32'd0);
        chk("arst_flags", out_flags, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
